spi_sd_responder: RTL and testbench



---
 rtl/spi_sd_responder.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_spi_sd_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sd_responder.sv
// spi_sd_responder: SPI-mode SD card model answering CMD0/8/17/41/55/58/59.
// Oversamples SCK/CS_n/MOSI on spi_clk_i, frames 48-bit commands, drives MISO.
//
// Ports:
//   spi_clk_i, spi_rst_n_i          system clock, async active-low reset
//   spi_sck_i, spi_cs_n_i           SPI mode-0 clock and chip select
//   spi_mosi_i, spi_miso_o          serial data, MSB first
//   spi_cmdvalid_o                  1-cycle pulse per accepted frame
//   spi_cmdidx_o, spi_cmdarg_o      index/argument of last accepted frame
//   spi_ready_o                     card has left idle via ACMD41
module spi_sd_responder #(
   parameter int unsigned NCR_BYTES      = 1,
   parameter int unsigned ACMD41_RETRIES = 3,
   parameter logic [31:0] OCR            = 32'hC0FF8000,
   parameter int unsigned BLOCK_BYTES    = 512
) (
   input  logic        spi_clk_i,
   input  logic        spi_rst_n_i,
   input  logic        spi_sck_i,
   input  logic        spi_cs_n_i,
   input  logic        spi_mosi_i,
   output logic        spi_miso_o,
   output logic        spi_cmdvalid_o,
   output logic [5:0]  spi_cmdidx_o,
   output logic [31:0] spi_cmdarg_o,
   output logic        spi_ready_o
);

   localparam int unsigned IWR = $clog2(BLOCK_BYTES + 8);
   localparam int unsigned IW  = (IWR > 8) ? IWR : 8;
   localparam int unsigned RW  = $clog2(ACMD41_RETRIES + 2);

   localparam logic [IW-1:0] NCR_LAST  = IW'(NCR_BYTES - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(BLOCK_BYTES + 3);
   localparam logic [RW-1:0] RETRY_MAX = RW'(ACMD41_RETRIES);

   typedef enum logic [2:0] {
      S_HUNT, S_CMD, S_NCR, S_RESP, S_DATA
   } fsm_t;

   typedef enum logic [1:0] {
      C_NOINIT, C_IDLE, C_READY
   } card_t;

   // input synchronizers; sck_p_q is the previous synchronized SCK
   logic sck_m_q, sck_s_q, sck_p_q;
   logic cs_m_q, cs_s_q;
   logic mosi_m_q, mosi_s_q;

   fsm_t          fsm_q, fsm_d;
   card_t         card_q, card_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [6:0]    rx_q, rx_d;
   logic [7:0]    tx_q, tx_d;
   logic [2:0]    byte_cnt_q, byte_cnt_d;
   logic [5:0]    idx_buf_q, idx_buf_d;
   logic [31:0]   arg_buf_q, arg_buf_d;
   logic [5:0]    cmdidx_q, cmdidx_d;
   logic [31:0]   cmdarg_q, cmdarg_d;
   logic          cmdvalid_q, cmdvalid_d;
   logic          acmd_q, acmd_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [7:0]    r1_q, r1_d;
   logic [31:0]   trail_q, trail_d;
   logic          has_trail_q, has_trail_d;
   logic          data_en_q, data_en_d;
   logic [IW-1:0] tx_idx_q, tx_idx_d;
   logic          last_q, last_d;

   logic          rise, fall, byte_done, tx_state, idle_bit;
   logic [7:0]    rx_byte;
   logic [7:0]    payload;
   logic          resp_end;

   logic [7:0]    dec_r1;
   logic [31:0]   dec_trail;
   logic          dec_has_trail, dec_data;
   card_t         dec_card;
   logic [RW-1:0] dec_retry;

   always_ff @(posedge spi_clk_i or negedge spi_rst_n_i) begin
      if (!spi_rst_n_i) begin
         sck_m_q  <= 1'b0;
         sck_s_q  <= 1'b0;
         sck_p_q  <= 1'b0;
         cs_m_q   <= 1'b1;
         cs_s_q   <= 1'b1;
         mosi_m_q <= 1'b1;
         mosi_s_q <= 1'b1;
      end else begin
         sck_m_q  <= spi_sck_i;
         sck_s_q  <= sck_m_q;
         sck_p_q  <= sck_s_q;
         cs_m_q   <= spi_cs_n_i;
         cs_s_q   <= cs_m_q;
         mosi_m_q <= spi_mosi_i;
         mosi_s_q <= mosi_m_q;
      end
   end

   assign rise      = sck_s_q & ~sck_p_q;
   assign fall      = ~sck_s_q & sck_p_q;
   assign rx_byte   = {rx_q, mosi_s_q};
   assign byte_done = rise && (bit_cnt_q == 3'd7);
   assign idle_bit  = (card_q != C_READY);
   assign tx_state  = (fsm_q == S_NCR) || (fsm_q == S_RESP) ||
                      (fsm_q == S_DATA);
   assign payload   = 8'(tx_idx_q - IW'(2)) + cmdarg_q[7:0];
   assign resp_end  = has_trail_q ? (tx_idx_q == IW'(4)) :
                                    (tx_idx_q == '0);

   always_comb begin
      fsm_d       = fsm_q;
      card_d      = card_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      byte_cnt_d  = byte_cnt_q;
      idx_buf_d   = idx_buf_q;
      arg_buf_d   = arg_buf_q;
      cmdidx_d    = cmdidx_q;
      cmdarg_d    = cmdarg_q;
      cmdvalid_d  = 1'b0;
      acmd_d      = acmd_q;
      retry_d     = retry_q;
      r1_d        = r1_q;
      trail_d     = trail_q;
      has_trail_d = has_trail_q;
      data_en_d   = data_en_q;
      tx_idx_d    = tx_idx_q;
      last_d      = last_q;

      // response decode for the frame held in idx_buf_q/arg_buf_q
      dec_r1        = {5'd0, 1'b1, 1'b0, idle_bit};
      dec_trail     = '0;
      dec_has_trail = 1'b0;
      dec_data      = 1'b0;
      dec_card      = card_q;
      dec_retry     = retry_q;
      if (idx_buf_q == 6'd0) begin
         dec_card  = C_IDLE;
         dec_retry = '0;
         dec_r1    = 8'h01;
      end else if (card_q == C_NOINIT) begin
         dec_r1 = 8'h05;
      end else begin
         case (idx_buf_q)
            6'd8: begin
               dec_r1        = {7'd0, idle_bit};
               dec_trail     = {16'h0000, 8'h01, arg_buf_q[7:0]};
               dec_has_trail = 1'b1;
            end
            6'd55, 6'd59: dec_r1 = {7'd0, idle_bit};
            6'd58: begin
               dec_r1        = {7'd0, idle_bit};
               dec_trail     = OCR;
               dec_has_trail = 1'b1;
            end
            6'd41: begin
               if (acmd_q) begin
                  if (retry_q < RETRY_MAX) begin
                     dec_retry = retry_q + RW'(1);
                     dec_r1    = 8'h01;
                  end else begin
                     dec_card = C_READY;
                     dec_r1   = 8'h00;
                  end
               end
            end
            6'd17: begin
               if (card_q == C_READY) begin
                  dec_r1   = 8'h00;
                  dec_data = 1'b1;
               end else begin
                  dec_r1 = 8'h05;
               end
            end
            default: ;
         endcase
      end

      if (cs_s_q) begin
         // deselect drops any frame or transfer in progress
         fsm_d     = S_HUNT;
         bit_cnt_d = '0;
         last_d    = 1'b0;
      end else begin
         if (rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
         end

         // a fall with bit_cnt at 0 follows bit 7: load the next byte
         if (fall) begin
            if (tx_state && bit_cnt_q == 3'd0) begin
               tx_idx_d = tx_idx_q + IW'(1);
               unique case (1'b1)
                  fsm_q == S_NCR: begin
                     tx_d = 8'hFF;
                     if (tx_idx_q == NCR_LAST) begin
                        fsm_d    = S_RESP;
                        tx_idx_d = '0;
                     end
                  end
                  fsm_q == S_RESP: begin
                     if (tx_idx_q == '0) begin
                        tx_d = r1_q;
                     end else begin
                        tx_d    = trail_q[31:24];
                        trail_d = {trail_q[23:0], 8'h00};
                     end
                     if (resp_end) begin
                        if (data_en_q) begin
                           fsm_d    = S_DATA;
                           tx_idx_d = '0;
                        end else begin
                           last_d = 1'b1;
                        end
                     end
                  end
                  default: begin
                     if (tx_idx_q == '0) begin
                        tx_d = 8'hFF;
                     end else if (tx_idx_q == IW'(1)) begin
                        tx_d = 8'hFE;
                     end else if (tx_idx_q >= DATA_LAST - IW'(1)) begin
                        tx_d = 8'hFF;
                     end else begin
                        tx_d = payload;
                     end
                     if (tx_idx_q == DATA_LAST) begin
                        last_d = 1'b1;
                     end
                  end
               endcase
            end else begin
               tx_d = {tx_q[6:0], 1'b1};
            end
         end

         case (fsm_q)
            S_HUNT: begin
               if (byte_done && rx_byte[7:6] == 2'b01) begin
                  idx_buf_d  = rx_byte[5:0];
                  byte_cnt_d = 3'd1;
                  fsm_d      = S_CMD;
               end
            end
            S_CMD: begin
               if (byte_done) begin
                  if (byte_cnt_q == 3'd5) begin
                     // CRC byte closes the frame; CRC itself is ignored
                     cmdidx_d    = idx_buf_q;
                     cmdarg_d    = arg_buf_q;
                     cmdvalid_d  = 1'b1;
                     card_d      = dec_card;
                     retry_d     = dec_retry;
                     acmd_d      = (idx_buf_q == 6'd55);
                     r1_d        = dec_r1;
                     trail_d     = dec_trail;
                     has_trail_d = dec_has_trail;
                     data_en_d   = dec_data;
                     tx_idx_d    = '0;
                     tx_d        = 8'hFF;
                     last_d      = 1'b0;
                     fsm_d       = S_NCR;
                  end else begin
                     arg_buf_d  = {arg_buf_q[23:0], rx_byte};
                     byte_cnt_d = byte_cnt_q + 3'd1;
                  end
               end
            end
            default: begin
               // host bytes here are ignored; the last sent byte ends it
               if (byte_done && last_q) begin
                  fsm_d  = S_HUNT;
                  last_d = 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge spi_clk_i or negedge spi_rst_n_i) begin
      if (!spi_rst_n_i) begin
         fsm_q       <= S_HUNT;
         card_q      <= C_NOINIT;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= 8'hFF;
         byte_cnt_q  <= '0;
         idx_buf_q   <= '0;
         arg_buf_q   <= '0;
         cmdidx_q    <= '0;
         cmdarg_q    <= '0;
         cmdvalid_q  <= 1'b0;
         acmd_q      <= 1'b0;
         retry_q     <= '0;
         r1_q        <= 8'hFF;
         trail_q     <= '0;
         has_trail_q <= 1'b0;
         data_en_q   <= 1'b0;
         tx_idx_q    <= '0;
         last_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         card_q      <= card_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         byte_cnt_q  <= byte_cnt_d;
         idx_buf_q   <= idx_buf_d;
         arg_buf_q   <= arg_buf_d;
         cmdidx_q    <= cmdidx_d;
         cmdarg_q    <= cmdarg_d;
         cmdvalid_q  <= cmdvalid_d;
         acmd_q      <= acmd_d;
         retry_q     <= retry_d;
         r1_q        <= r1_d;
         trail_q     <= trail_d;
         has_trail_q <= has_trail_d;
         data_en_q   <= data_en_d;
         tx_idx_q    <= tx_idx_d;
         last_q      <= last_d;
      end
   end

   assign spi_miso_o = (tx_state && !cs_s_q && !spi_cs_n_i) ?
                       tx_q[7] : 1'b1;
   assign spi_cmdvalid_o = cmdvalid_q;
   assign spi_cmdidx_o   = cmdidx_q;
   assign spi_cmdarg_o   = cmdarg_q;
   assign spi_ready_o    = (card_q == C_READY);

endmodule

// File: tb/tb_spi_sd_responder.sv
// tb_spi_sd_responder: directed SPI host driving spi_sd_responder.
// Expected MISO bytes and command frames are queued and checked by monitors.
module tb_spi_sd_responder;

   localparam int HALF = 5;

   logic        spi_clk_i   = 1'b0;
   logic        spi_rst_n_i = 1'b0;
   logic        spi_sck_i   = 1'b0;
   logic        spi_cs_n_i  = 1'b1;
   logic        spi_mosi_i  = 1'b1;
   logic        spi_miso_o;
   logic        spi_cmdvalid_o;
   logic [5:0]  spi_cmdidx_o;
   logic [31:0] spi_cmdarg_o;
   logic        spi_ready_o;

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_q[$];
   logic [37:0] cmd_q[$];

   localparam logic [47:0] CMD0   = 48'h40_00_00_00_00_95;
   localparam logic [47:0] CMD8   = 48'h48_00_00_01_AA_87;
   localparam logic [47:0] CMD12  = 48'h4C_00_00_00_00_61;
   localparam logic [47:0] CMD55  = 48'h77_00_00_00_00_65;
   localparam logic [47:0] ACMD41 = 48'h69_40_00_00_00_77;
   localparam logic [47:0] CMD58  = 48'h7A_00_00_00_00_FD;
   localparam logic [47:0] CMD17A = 48'h51_00_00_28_00_FF;
   localparam logic [47:0] CMD17B = 48'h51_00_00_00_05_FF;

   spi_sd_responder dut (
      .spi_clk_i      (spi_clk_i),
      .spi_rst_n_i    (spi_rst_n_i),
      .spi_sck_i      (spi_sck_i),
      .spi_cs_n_i     (spi_cs_n_i),
      .spi_mosi_i     (spi_mosi_i),
      .spi_miso_o     (spi_miso_o),
      .spi_cmdvalid_o (spi_cmdvalid_o),
      .spi_cmdidx_o   (spi_cmdidx_o),
      .spi_cmdarg_o   (spi_cmdarg_o),
      .spi_ready_o    (spi_ready_o)
   );

   always #5 spi_clk_i = ~spi_clk_i;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // MISO monitor: assembles a byte every 8 SCK rises while selected
   initial begin
      int mcnt;
      logic [7:0] mb;
      mcnt = 0;
      mb   = 8'h00;
      forever begin
         @(posedge spi_sck_i or posedge spi_cs_n_i);
         if (spi_cs_n_i) begin
            mcnt = 0;
         end else begin
            mb = {mb[6:0], spi_miso_o};
            mcnt++;
            if (mcnt == 8) begin
               mcnt = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL miso_byte got=%h exp=none", mb);
               end else begin
                  chk("miso_byte", {24'h0, mb}, {24'h0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   // command monitor: one pop per cycle of spi_cmdvalid_o
   initial begin
      logic [37:0] e;
      forever begin
         @(negedge spi_clk_i);
         if (spi_cmdvalid_o) begin
            if (cmd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cmd_pulse got idx=%0d exp=none", spi_cmdidx_o);
            end else begin
               e = cmd_q.pop_front();
               chk("cmd_idx", {26'h0, spi_cmdidx_o}, {26'h0, e[37:32]});
               chk("cmd_arg", spi_cmdarg_o, e[31:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic xfer(input logic [7:0] m, input logic [7:0] e);
      exp_q.push_back(e);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi_i = m[i];
         repeat (HALF) @(negedge spi_clk_i);
         spi_sck_i = 1'b1;
         repeat (HALF) @(negedge spi_clk_i);
         spi_sck_i = 1'b0;
      end
   endtask

   task automatic rd(input logic [7:0] e);
      xfer(8'hFF, e);
   endtask

   task automatic frame(input logic [47:0] f);
      cmd_q.push_back({f[45:40], f[39:8]});
      for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], 8'hFF);
   endtask

   task automatic cs_lo();
      spi_cs_n_i = 1'b0;
      repeat (6) @(negedge spi_clk_i);
   endtask

   task automatic cs_hi();
      repeat (HALF) @(negedge spi_clk_i);
      spi_cs_n_i = 1'b1;
      spi_mosi_i = 1'b1;
      repeat (8) @(negedge spi_clk_i);
   endtask

   initial begin
      repeat (4) @(negedge spi_clk_i);
      chk("rst_miso", {31'h0, spi_miso_o}, 32'h1);
      chk("rst_valid", {31'h0, spi_cmdvalid_o}, 32'h0);
      chk("rst_idx", {26'h0, spi_cmdidx_o}, 32'h0);
      chk("rst_arg", spi_cmdarg_o, 32'h0);
      chk("rst_ready", {31'h0, spi_ready_o}, 32'h0);
      spi_rst_n_i = 1'b1;
      repeat (4) @(negedge spi_clk_i);

      // NOINIT: anything but CMD0 is illegal, no trailing bytes
      cs_lo();
      frame(CMD8);
      rd(8'hFF); rd(8'h05); rd(8'hFF);
      cs_hi();

      cs_lo();
      frame(CMD0);
      rd(8'hFF); rd(8'h01);
      cs_hi();

      // partial frame dropped, then a full CMD0
      cs_lo();
      xfer(8'h40, 8'hFF); xfer(8'h00, 8'hFF); xfer(8'h00, 8'hFF);
      cs_hi();
      cs_lo();
      frame(CMD0);
      rd(8'hFF); rd(8'h01);

      // back-to-back in the same selection
      frame(CMD8);
      rd(8'hFF); rd(8'h01); rd(8'h00); rd(8'h00); rd(8'h01); rd(8'hAA);
      chk("cmd8_arg", spi_cmdarg_o, 32'h0000_01AA);
      frame(CMD12);
      rd(8'hFF); rd(8'h05); rd(8'hFF);
      cs_hi();

      chk("ready_pre", {31'h0, spi_ready_o}, 32'h0);
      cs_lo();
      for (int i = 0; i < 4; i++) begin
         frame(CMD55);
         rd(8'hFF); rd(8'h01);
         frame(ACMD41);
         rd(8'hFF); rd((i < 3) ? 8'h01 : 8'h00);
         chk("ready_acmd", {31'h0, spi_ready_o}, (i == 3) ? 32'h1 : 32'h0);
      end
      frame(CMD58);
      rd(8'hFF); rd(8'h00); rd(8'hC0); rd(8'hFF); rd(8'h80); rd(8'h00);
      cs_hi();

      cs_lo();
      frame(CMD17A);
      rd(8'hFF); rd(8'h00); rd(8'hFF); rd(8'hFE);
      for (int k = 0; k < 512; k++) rd(8'(k));
      rd(8'hFF); rd(8'hFF); rd(8'hFF);
      cs_hi();

      // reset in the middle of a data block
      cs_lo();
      frame(CMD17B);
      rd(8'hFF); rd(8'h00); rd(8'hFF); rd(8'hFE);
      rd(8'h05); rd(8'h06); rd(8'h07);
      repeat (4) @(negedge spi_clk_i);
      chk("miso_pre_rst", {31'h0, spi_miso_o}, 32'h0);
      spi_rst_n_i = 1'b0;
      #1;
      chk("miso_in_rst", {31'h0, spi_miso_o}, 32'h1);
      chk("ready_in_rst", {31'h0, spi_ready_o}, 32'h0);
      repeat (3) @(negedge spi_clk_i);
      spi_cs_n_i = 1'b1;
      repeat (3) @(negedge spi_clk_i);
      spi_rst_n_i = 1'b1;
      repeat (4) @(negedge spi_clk_i);

      cs_lo();
      frame(CMD55);
      rd(8'hFF); rd(8'h05); rd(8'hFF);
      cs_hi();

      repeat (20) @(negedge spi_clk_i);
      chk("exp_q_empty", exp_q.size(), 32'h0);
      chk("cmd_q_empty", cmd_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
